// File: rtl/bm_solver_param.sv
// bm_solver_param: inversionless Berlekamp-Massey key-equation solver, GF(2^M).
// Optional feature macro: BM_FAIL_DETECT_EN (uncorrectable-flag logic).
module bm_solver_param #(
  parameter int         M         = 8,
  parameter logic [M:0] PRIM_POLY = 9'h11D,
  parameter int         MAX_NSYN  = 16,
  parameter int         NW        = $clog2(MAX_NSYN + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [NW-1:0] nsyn,
  input  logic [M-1:0]  syn_in,
  input  logic          syn_valid,
  output logic          syn_ready,
  output logic [M-1:0]  coef_out,
  output logic [NW-1:0] coef_idx,
  output logic          coef_valid,
  input  logic          coef_ready,
  output logic          coef_last,
  output logic [NW-1:0] deg_out,
  output logic          fail,
  output logic          busy
);

  localparam int HALF = MAX_NSYN / 2;
  localparam logic [NW-1:0] NMAX   = NW'(MAX_NSYN);
  localparam logic [NW-1:0] ONE    = NW'(1);
  localparam logic [M-1:0]  GF_ONE = M'(1);
  localparam logic [M-1:0]  POLY   = PRIM_POLY[M-1:0];

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_CALC = 3'd2;
  localparam logic [2:0] S_UPD  = 3'd3;
  localparam logic [2:0] S_OUT  = 3'd4;

  function automatic logic [M-1:0] gf_mul(
    input logic [M-1:0] a,
    input logic [M-1:0] b
  );
    logic [M-1:0] p;
    logic [M-1:0] x;
    p = '0;
    x = a;
    for (int k = 0; k < M; k++) begin
      if (b[k]) p = p ^ x;
      x = x[M-1] ? ((x << 1) ^ POLY) : (x << 1);
    end
    return p;
  endfunction

  logic [2:0]    state_q, state_d;
  logic [NW-1:0] n_q, n_d;
  logic [NW-1:0] j_q, j_d;
  logic [NW-1:0] nn_q, nn_d;
  logic [NW-1:0] l_q, l_d;
  logic [NW-1:0] m_q, m_d;
  logic [NW-1:0] idx_q, idx_d;
  logic [NW-1:0] deg_q;
  logic [M-1:0]  b_q, b_d;
  logic [M-1:0]  d_q, d_d;
  logic [M-1:0]  d_calc;
  logic          live_q, live_d;
  logic          enter_out;

  logic [M-1:0] c_q   [0:MAX_NSYN];
  logic [M-1:0] c_d   [0:MAX_NSYN];
  logic [M-1:0] bb_q  [0:MAX_NSYN];
  logic [M-1:0] bb_d  [0:MAX_NSYN];
  logic [M-1:0] s_q   [0:MAX_NSYN];
  logic [M-1:0] s_d   [0:MAX_NSYN];
  logic [M-1:0] c_upd [0:MAX_NSYN];

  // Discrepancy: sum of C_i * S[N+1-i]; S_j lives at s_q[j-1].
  always_comb begin
    d_calc = '0;
    for (int i = 0; i <= HALF; i++) begin
      if (NW'(i) <= l_q && NW'(i) <= nn_q)
        d_calc = d_calc ^ gf_mul(c_q[i], s_q[nn_q - NW'(i)]);
    end
  end

  // Candidate locator b*C + d*x^m*B, terms past MAX_NSYN dropped.
  always_comb begin
    for (int i = 0; i <= MAX_NSYN; i++) begin
      c_upd[i] = gf_mul(b_q, c_q[i]);
      if (m_q <= NW'(i))
        c_upd[i] = c_upd[i] ^ gf_mul(d_q, bb_q[NW'(i) - m_q]);
    end
  end

  // Control FSM and BM iteration next-state.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    j_d     = j_q;
    nn_d    = nn_q;
    l_d     = l_q;
    m_d     = m_q;
    b_d     = b_q;
    d_d     = d_q;
    idx_d   = idx_q;
    live_d  = live_q;
    c_d     = c_q;
    bb_d    = bb_q;
    s_d     = s_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d    = (nsyn > NMAX) ? NMAX : nsyn;
          j_d    = '0;
          nn_d   = '0;
          l_d    = '0;
          m_d    = ONE;
          b_d    = GF_ONE;
          idx_d  = '0;
          live_d = 1'b0;
          for (int i = 0; i <= MAX_NSYN; i++) begin
            c_d[i]  = '0;
            bb_d[i] = '0;
          end
          c_d[0]  = GF_ONE;
          bb_d[0] = GF_ONE;
          state_d = (n_d == '0) ? S_OUT : S_LOAD;
        end
      end
      S_LOAD: begin
        if (syn_valid) begin
          s_d[j_q] = syn_in;
          j_d      = j_q + ONE;
          if (j_d == n_q) state_d = S_CALC;
        end
      end
      S_CALC: begin
        d_d     = d_calc;
        state_d = S_UPD;
      end
      S_UPD: begin
        if (d_q == '0) begin
          m_d = m_q + ONE;
        end else begin
          c_d = c_upd;
          if ({l_q, 1'b0} <= {1'b0, nn_q}) begin
            l_d  = nn_q + ONE - l_q;
            bb_d = c_q;
            b_d  = d_q;
            m_d  = ONE;
          end else begin
            m_d = m_q + ONE;
          end
        end
        nn_d    = nn_q + ONE;
        state_d = (nn_d == n_q) ? S_OUT : S_CALC;
      end
      S_OUT: begin
        if (!live_q) begin
          live_d = 1'b1;
        end else if (coef_ready) begin
          if (idx_q == l_q) begin
            state_d = S_IDLE;
            live_d  = 1'b0;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + ONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign enter_out = (state_d == S_OUT) && (state_q != S_OUT);

  // State registers; degree captured on the way into OUTPUT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      j_q     <= '0;
      nn_q    <= '0;
      l_q     <= '0;
      m_q     <= '0;
      idx_q   <= '0;
      deg_q   <= '0;
      b_q     <= '0;
      d_q     <= '0;
      live_q  <= 1'b0;
      for (int i = 0; i <= MAX_NSYN; i++) begin
        c_q[i]  <= '0;
        bb_q[i] <= '0;
        s_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      j_q     <= j_d;
      nn_q    <= nn_d;
      l_q     <= l_d;
      m_q     <= m_d;
      idx_q   <= idx_d;
      b_q     <= b_d;
      d_q     <= d_d;
      live_q  <= live_d;
      c_q     <= c_d;
      bb_q    <= bb_d;
      s_q     <= s_d;
      if (enter_out) deg_q <= l_d;
    end
  end

`ifdef BM_FAIL_DETECT_EN
  logic fail_q, fail_d;

  // Uncorrectable: degree beyond capacity or leading coefficient vanished.
  always_comb begin
    fail_d = (l_d > (n_d >> 1)) || (c_d[l_d] == '0);
  end

  // Flag held from OUTPUT entry until the next result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) fail_q <= 1'b0;
    else if (enter_out) fail_q <= fail_d;
  end

  assign fail = fail_q;
`else
  assign fail = 1'b0;
`endif

  assign busy       = (state_q != S_IDLE);
  assign syn_ready  = (state_q == S_LOAD);
  assign coef_valid = (state_q == S_OUT) && live_q;
  assign coef_out   = coef_valid ? c_q[idx_q] : '0;
  assign coef_idx   = idx_q;
  assign coef_last  = coef_valid && (idx_q == l_q);
  assign deg_out    = deg_q;

endmodule

// File: tb/tb_bm_solver_param.sv
// tb_bm_solver_param: directed and randomized checks of bm_solver_param.
// Locators are judged by their roots against known error positions.
module tb_bm_solver_param;

  localparam int M    = 8;
  localparam int MAXN = 16;
  localparam int NW   = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [NW-1:0] nsyn;
  logic [M-1:0]  syn_in;
  logic          syn_valid;
  logic          syn_ready;
  logic [M-1:0]  coef_out;
  logic [NW-1:0] coef_idx;
  logic          coef_valid;
  logic          coef_ready;
  logic          coef_last;
  logic [NW-1:0] deg_out;
  logic          fail;
  logic          busy;

  bm_solver_param dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .nsyn       (nsyn),
    .syn_in     (syn_in),
    .syn_valid  (syn_valid),
    .syn_ready  (syn_ready),
    .coef_out   (coef_out),
    .coef_idx   (coef_idx),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .coef_last  (coef_last),
    .deg_out    (deg_out),
    .fail       (fail),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [7:0] syn_tb [0:31];
  logic [7:0] got_c [$];
  int         got_i [$];
  int         got_l [$];
  int got_deg, got_fail, syn_beats, lat, timeouts;
  int stall_bad, busy_after, last_beat, first_valid;
  int exp_tab [0:255];
  int log_tab [0:255];

`ifdef BM_FAIL_DETECT_EN
  localparam int OVER_FAIL = 1;
`else
  localparam int OVER_FAIL = 0;
`endif

  function automatic int gmul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return exp_tab[(log_tab[a] + log_tab[b]) % 255];
  endfunction

  task automatic build_tables();
    int v;
    v = 1;
    for (int i = 0; i < 256; i++) log_tab[i] = 0;
    for (int i = 0; i < 255; i++) begin
      exp_tab[i] = v;
      log_tab[v] = i;
      v = v << 1;
      if (v > 255) v = v ^ 'h11D;
    end
    exp_tab[255] = 1;
  endtask

  // Runs one codeword; abort_at >= 0 returns that many cycles after loading.
  task automatic run_cw(input int nv, input int mode, input int abort_at);
    int guard, ph;
    bit pv;
    logic [7:0] hc;
    logic [NW-1:0] hi;
    got_c.delete();
    got_i.delete();
    got_l.delete();
    syn_beats = 0; timeouts = 0; stall_bad = 0;
    lat = -1; first_valid = -1; busy_after = -1;
    got_deg = -1; got_fail = -1;
    start = 1'b1;
    nsyn = NW'(nv);
    @(negedge clk);
    start = 1'b0;
    last_beat = cyc;
    guard = 0;
    while (syn_ready && guard < 200) begin
      if ($urandom_range(3, 0) == 0) begin
        syn_valid = 1'b0;
      end else begin
        syn_valid = 1'b1;
        syn_in = syn_tb[syn_beats];
        syn_beats++;
        last_beat = cyc + 1;
      end
      @(negedge clk);
      guard++;
    end
    syn_valid = 1'b0;
    if (guard >= 200) timeouts++;
    if (abort_at >= 0) begin
      repeat (abort_at) @(negedge clk);
      return;
    end
    guard = 0; pv = 0; ph = 0; hc = '0; hi = '0;
    while (guard < 400) begin
      if (coef_valid && first_valid < 0) begin
        first_valid = cyc;
        lat = cyc - last_beat;
      end
      if (pv) begin
        if (coef_out !== hc || coef_idx !== hi || coef_valid !== 1'b1)
          stall_bad++;
      end
      case (mode)
        0: coef_ready = 1'b1;
        1: coef_ready = (first_valid >= 0) && (ph % 4 == 0 || ph % 4 == 3);
        default: coef_ready = 1'($urandom_range(1, 0));
      endcase
      if (first_valid >= 0) ph++;
      pv = coef_valid && !coef_ready;
      hc = coef_out;
      hi = coef_idx;
      if (coef_valid && coef_ready) begin
        got_c.push_back(coef_out);
        got_i.push_back(int'(coef_idx));
        got_l.push_back(int'(coef_last));
        got_deg = int'(deg_out);
        got_fail = int'(fail);
        if (coef_last) begin
          @(negedge clk);
          busy_after = int'(busy);
          break;
        end
      end
      @(negedge clk);
      guard++;
    end
    coef_ready = 1'b0;
    if (guard >= 400) timeouts++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks += 8;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (syn_ready !== 1'b0) begin errors++; $display("FAIL reset_syn_ready: got %b want 0", syn_ready); end
    if (coef_valid !== 1'b0) begin errors++; $display("FAIL reset_coef_valid: got %b want 0", coef_valid); end
    if (coef_last !== 1'b0) begin errors++; $display("FAIL reset_coef_last: got %b want 0", coef_last); end
    if (coef_out !== 8'h00) begin errors++; $display("FAIL reset_coef_out: got %h want 00", coef_out); end
    if (coef_idx !== 5'd0) begin errors++; $display("FAIL reset_coef_idx: got %0d want 0", coef_idx); end
    if (deg_out !== 5'd0) begin errors++; $display("FAIL reset_deg_out: got %0d want 0", deg_out); end
    if (fail !== 1'b0) begin errors++; $display("FAIL reset_fail: got %b want 0", fail); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zero();
    for (int i = 0; i < 4; i++) syn_tb[i] = 8'h00;
    for (int r = 0; r < 2; r++) begin
      run_cw(r == 0 ? 4 : 0, 0, -1);
      checks += 5;
      if (timeouts !== 0) begin errors++; $display("FAIL zero_timeout: got %0d want 0", timeouts); end
      if (got_c.size() !== 1) begin errors++; $display("FAIL zero_beats: got %0d want 1", got_c.size()); end
      else if (got_c[0] !== 8'h01 || got_l[0] !== 1) begin
        errors++; $display("FAIL zero_coef: got %h last %0d want 01 last 1", got_c[0], got_l[0]);
      end
      if (got_deg !== 0) begin errors++; $display("FAIL zero_deg: got %0d want 0", got_deg); end
      if (got_fail !== 0) begin errors++; $display("FAIL zero_fail: got %0d want 0", got_fail); end
    end
  endtask

  task automatic load_case2();
    syn_tb[0] = 8'h08; syn_tb[1] = 8'h40; syn_tb[2] = 8'h3A; syn_tb[3] = 8'hCD;
  endtask

  task automatic check_case2(input string tag);
    checks += 5;
    if (timeouts !== 0) begin errors++; $display("FAIL %s_timeout: got %0d want 0", tag, timeouts); end
    if (got_deg !== 1) begin errors++; $display("FAIL %s_deg: got %0d want 1", tag, got_deg); end
    if (got_fail !== 0) begin errors++; $display("FAIL %s_fail: got %0d want 0", tag, got_fail); end
    if (got_c.size() !== 2) begin errors++; $display("FAIL %s_beats: got %0d want 2", tag, got_c.size()); end
    else if (got_c[0] !== 8'h01 || got_c[1] !== 8'h08 || got_i[1] !== 1 || got_l[0] !== 0 || got_l[1] !== 1) begin
      errors++;
      $display("FAIL %s_coefs: got %h %h idx %0d last %0d%0d want 01 08 idx 1 last 01",
               tag, got_c[0], got_c[1], got_i[1], got_l[0], got_l[1]);
    end
    if (lat !== 9) begin errors++; $display("FAIL %s_latency: got %0d want 9", tag, lat); end
  endtask

  task automatic test_single();
    load_case2();
    run_cw(4, 0, -1);
    check_case2("single");
  endtask

  task automatic test_over();
    logic [7:0] want [0:4];
    want[0] = 8'h01; want[1] = 8'h00; want[2] = 8'h00; want[3] = 8'h00; want[4] = 8'h01;
    syn_tb[0] = 8'h00; syn_tb[1] = 8'h00; syn_tb[2] = 8'h00; syn_tb[3] = 8'h01;
    run_cw(4, 0, -1);
    checks += 3;
    if (got_deg !== 4) begin errors++; $display("FAIL over_deg: got %0d want 4", got_deg); end
    if (got_fail !== OVER_FAIL) begin errors++; $display("FAIL over_fail: got %0d want %0d", got_fail, OVER_FAIL); end
    if (got_c.size() !== 5) begin errors++; $display("FAIL over_beats: got %0d want 5", got_c.size()); end
    else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (got_c[i] !== want[i] || got_i[i] !== i) begin
          errors++;
          $display("FAIL over_coef%0d: got %h idx %0d want %h idx %0d", i, got_c[i], got_i[i], want[i], i);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    load_case2();
    run_cw(4, 1, -1);
    check_case2("bp");
    checks += 2;
    if (stall_bad !== 0) begin errors++; $display("FAIL bp_hold: got %0d changes want 0", stall_bad); end
    if (busy_after !== 0) begin errors++; $display("FAIL bp_busy_after: got %0d want 0", busy_after); end
  endtask

  task automatic test_reset_mid();
    load_case2();
    run_cw(4, 0, 1);
    reset = 1'b1;
    #1;
    checks += 5;
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", busy); end
    if (deg_out !== 5'd0) begin errors++; $display("FAIL mid_deg: got %0d want 0", deg_out); end
    if (coef_valid !== 1'b0) begin errors++; $display("FAIL mid_coef_valid: got %b want 0", coef_valid); end
    if (syn_ready !== 1'b0) begin errors++; $display("FAIL mid_syn_ready: got %b want 0", syn_ready); end
    if (fail !== 1'b0) begin errors++; $display("FAIL mid_fail: got %b want 0", fail); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || coef_valid !== 1'b0) begin
      errors++; $display("FAIL mid_idle_after: got busy %b valid %b want 0 0", busy, coef_valid);
    end
    run_cw(4, 0, -1);
    check_case2("rerun");
  endtask

  task automatic test_clamp();
    for (int i = 0; i < MAXN + 3; i++) syn_tb[i] = 8'($urandom_range(255, 0));
    run_cw(MAXN + 3, 0, -1);
    checks += 3;
    if (syn_beats !== MAXN) begin errors++; $display("FAIL clamp_beats: got %0d want %0d", syn_beats, MAXN); end
    if (timeouts !== 0) begin errors++; $display("FAIL clamp_timeout: got %0d want 0", timeouts); end
    if (got_c.size() !== got_deg + 1) begin
      errors++; $display("FAIL clamp_out_beats: got %0d want %0d", got_c.size(), got_deg + 1);
    end
  endtask

  task automatic test_random();
    int n, e, s, acc, ok;
    int p [0:7];
    int ev [0:7];
    for (int t = 0; t < 500; t++) begin
      n = $urandom_range(MAXN, 1);
      e = $urandom_range(n / 2, 0);
      for (int k = 0; k < e; k++) begin
        do begin
          p[k] = $urandom_range(254, 0);
          ok = 1;
          for (int q = 0; q < k; q++) if (p[q] == p[k]) ok = 0;
        end while (!ok);
        ev[k] = $urandom_range(255, 1);
      end
      for (int j = 1; j <= n; j++) begin
        s = 0;
        for (int k = 0; k < e; k++) s = s ^ gmul(ev[k], exp_tab[(p[k] * j) % 255]);
        syn_tb[j-1] = 8'(s);
      end
      run_cw(n, 2, -1);
      checks += 6;
      if (timeouts !== 0) begin errors++; $display("FAIL rnd%0d_timeout: got %0d want 0", t, timeouts); end
      if (got_deg !== e) begin errors++; $display("FAIL rnd%0d_deg: got %0d want %0d", t, got_deg, e); end
      if (got_fail !== 0) begin errors++; $display("FAIL rnd%0d_fail: got %0d want 0", t, got_fail); end
      if (lat !== 2 * n + 1) begin errors++; $display("FAIL rnd%0d_latency: got %0d want %0d", t, lat, 2 * n + 1); end
      if (stall_bad !== 0) begin errors++; $display("FAIL rnd%0d_hold: got %0d want 0", t, stall_bad); end
      if (got_c.size() !== e + 1) begin
        errors++; $display("FAIL rnd%0d_beats: got %0d want %0d", t, got_c.size(), e + 1);
      end else begin
        checks += 2;
        if (got_c[0] === 8'h00) begin errors++; $display("FAIL rnd%0d_c0: got 00 want nonzero", t); end
        ok = 1;
        for (int i = 0; i <= e; i++)
          if (got_i[i] !== i || got_l[i] !== (i == e ? 1 : 0)) ok = 0;
        if (!ok) begin errors++; $display("FAIL rnd%0d_idx_seq: got bad index/last sequence want 0..%0d", t, e); end
        for (int k = 0; k < e; k++) begin
          acc = 0;
          for (int i = 0; i <= e; i++)
            acc = acc ^ gmul(int'(got_c[i]), exp_tab[(255 - (p[k] * i) % 255) % 255]);
          checks++;
          if (acc !== 0) begin
            errors++; $display("FAIL rnd%0d_root%0d: got C(a^-%0d)=%h want 00", t, k, p[k], acc);
          end
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    nsyn = '0;
    syn_in = '0;
    syn_valid = 1'b0;
    coef_ready = 1'b0;
    build_tables();
    test_reset();
    test_zero();
    test_single();
    test_over();
    test_backpressure();
    test_reset_mid();
    test_clamp();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
